// File: rtl/adf4159_spi_monitor.sv
// Passive monitor for the ADF4159 3-wire programming bus: assembles 32-bit words,
// files them into an 11-entry shadow map and decodes the PLL frequency fields.
module adf4159_spi_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_BITS    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_data,
  input  logic        spi_le,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [3:0]  slot,
  output logic        frame_err,
  output logic        freq_update,
  output logic [11:0] int_val,
  output logic [24:0] frac_val,
  output logic        ref_doubled,
  output logic [4:0]  r_counter,
  output logic        prescaler,
  input  logic [3:0]  rd_slot,
  output logic [31:0] rd_data
);

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned SLOT_W    = 4;
  localparam int unsigned NUM_SLOTS = 11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic [SYNC_STAGES-1:0] r_le_sync;
  logic                   r_clk_d;
  logic                   r_le_d;

  state_t              r_state;
  logic [WORD_W-1:0]   r_shift;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [WORD_W-1:0]   r_word;
  logic [SLOT_W-1:0]   r_slot;
  logic                r_word_valid;
  logic                r_frame_err;
  logic                r_freq_update;
  logic [WORD_W-1:0]   r_shadow [0:NUM_SLOTS-1];

  logic w_clk_rise;
  logic w_le_rise;
  logic w_le_hi;
  logic w_data;

  // Map a word to its shadow slot from the control bits and sub-select bits.
  function automatic logic [SLOT_W-1:0] f_slot(input logic [WORD_W-1:0] w);
    logic [SLOT_W-1:0] s;
    case (w[2:0])
      3'd4:    s = w[6]  ? 4'd5 : 4'd4;
      3'd5:    s = w[23] ? 4'd7 : 4'd6;
      3'd6:    s = w[23] ? 4'd9 : 4'd8;
      3'd7:    s = 4'd10;
      default: s = {1'b0, w[2:0]};
    endcase
    return s;
  endfunction

  // Input synchronizers plus one edge-detect stage for clock and LE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync <= '0;
      r_dat_sync <= '0;
      r_le_sync  <= '0;
      r_clk_d    <= 1'b0;
      r_le_d     <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], spi_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], spi_data};
      r_le_sync  <= {r_le_sync[SYNC_STAGES-2:0], spi_le};
      r_clk_d    <= r_clk_sync[SYNC_STAGES-1];
      r_le_d     <= r_le_sync[SYNC_STAGES-1];
    end
  end

  assign w_clk_rise = r_clk_sync[SYNC_STAGES-1] & ~r_clk_d;
  assign w_le_hi    = r_le_sync[SYNC_STAGES-1];
  assign w_le_rise  = w_le_hi & ~r_le_d;
  assign w_data     = r_dat_sync[SYNC_STAGES-1];

  // Shift/commit FSM; the shadow write lands in COMMIT so decoded fields
  // follow word_valid by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_word        <= '0;
      r_slot        <= '0;
      r_word_valid  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_freq_update <= 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      r_word_valid  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_freq_update <= 1'b0;
      case (r_state)
        COMMIT: begin
          if (r_word_valid) begin
            r_shadow[r_slot] <= r_word;
          end
          r_state <= IDLE;
        end
        default: begin
          if (w_le_rise) begin
            if (r_bit_cnt == CNT_W'(MIN_BITS)) begin
              r_word        <= r_shift;
              r_slot        <= f_slot(r_shift);
              r_word_valid  <= 1'b1;
              r_freq_update <= (r_shift[2:0] == 3'd0);
            end else begin
              r_frame_err <= 1'b1;
            end
            r_bit_cnt <= '0;
            r_state   <= COMMIT;
          end else if (w_clk_rise && !w_le_hi) begin
            r_shift <= {r_shift[WORD_W-2:0], w_data};
            if (r_bit_cnt != CNT_MAX) begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            r_state <= SHIFT;
          end
        end
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_slot < SLOT_W'(NUM_SLOTS)) begin
      rd_data = r_shadow[rd_slot];
    end
  end

  assign word_valid  = r_word_valid;
  assign word        = r_word;
  assign slot        = r_slot;
  assign frame_err   = r_frame_err;
  assign freq_update = r_freq_update;
  assign int_val     = r_shadow[0][26:15];
  assign frac_val    = {r_shadow[0][14:3], r_shadow[1][27:15]};
  assign ref_doubled = r_shadow[2][20];
  assign r_counter   = r_shadow[2][19:15];
  assign prescaler   = r_shadow[2][22];

endmodule
